// File: rtl/tartaruga_pkg.sv
// Shared types for the store buffer: geometry, entry layout, size encoding
// and the lane/byte-enable helpers used on the memory side.
package tartaruga_pkg;

  localparam int STORE_BUFFER_SIZE = 4;
  localparam int SB_IDX_W          = $clog2(STORE_BUFFER_SIZE);

  typedef logic [SB_IDX_W-1:0] store_buffer_idx_t;

  typedef enum logic [1:0] {
    SB_BYTE = 2'd0,
    SB_HALF = 2'd1,
    SB_WORD = 2'd2
  } sb_size_t;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_PENDING   = 2'd1,
    SB_COMMITTED = 2'd2
  } sb_state_t;

  typedef struct packed {
    sb_state_t   state;
    sb_size_t    size;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  // Byte enables for a store; an out-of-range size behaves as a word.
  function automatic logic [3:0] sb_byte_en(input sb_size_t size, input logic [1:0] offset);
    case (size)
      SB_BYTE: return 4'b0001 << offset;
      SB_HALF: return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] sb_lane_data(input sb_size_t size, input logic [31:0] data);
    case (size)
      SB_BYTE: return {4{data[7:0]}};
      SB_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the store buffer's execute, retire, memory and load-lookup signals.
// master = surrounding pipeline/memory, slave = store_buffer.
interface store_buffer_if
  import tartaruga_pkg::*;
();

  logic                         alloc_valid_i;
  logic [31:0]                  alloc_addr_i;
  logic [31:0]                  alloc_data_i;
  logic [1:0]                   alloc_size_i;
  logic                         alloc_ready_o;
  store_buffer_idx_t            alloc_idx_o;

  logic                         commit_valid_i;
  store_buffer_idx_t            commit_idx_i;
  logic [STORE_BUFFER_SIZE-1:0] discard_i;

  logic                         mem_req_valid_o;
  logic                         mem_req_ready_i;
  logic [31:0]                  mem_addr_o;
  logic [31:0]                  mem_data_o;
  logic [3:0]                   mem_be_o;

  logic [31:0]                  ld_addr_i;
  logic                         ld_fwd_hit_o;
  logic [31:0]                  ld_fwd_data_o;
  logic                         ld_stall_o;

  logic                         full_o;
  logic                         empty_o;

  modport master (
    output alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_size_i,
    input  alloc_ready_o, alloc_idx_o,
    output commit_valid_i, commit_idx_i, discard_i,
    input  mem_req_valid_o, mem_addr_o, mem_data_o, mem_be_o,
    output mem_req_ready_i,
    output ld_addr_i,
    input  ld_fwd_hit_o, ld_fwd_data_o, ld_stall_o,
    input  full_o, empty_o
  );

  modport slave (
    input  alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_size_i,
    output alloc_ready_o, alloc_idx_o,
    input  commit_valid_i, commit_idx_i, discard_i,
    output mem_req_valid_o, mem_addr_o, mem_data_o, mem_be_o,
    input  mem_req_ready_i,
    input  ld_addr_i,
    output ld_fwd_hit_o, ld_fwd_data_o, ld_stall_o,
    output full_o, empty_o
  );

endinterface

// File: rtl/store_buffer_fwd.sv
// Youngest-match load lookup over the store buffer entries (pure combinational).
// Define STORE_BUFFER_FWD_EN to forward full-word matches instead of stalling.
module store_buffer_fwd
  import tartaruga_pkg::*;
(
  input  sb_entry_t         entry_i [STORE_BUFFER_SIZE],
  input  store_buffer_idx_t head_i,
  input  logic [31:0]       ld_addr_i,
  output logic              fwd_hit_o,
  output logic [31:0]       fwd_data_o,
  output logic              stall_o
);

  logic [STORE_BUFFER_SIZE-1:0] match;
  logic                         unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr_i[1:0];

  for (genvar gi = 0; gi < STORE_BUFFER_SIZE; gi++) begin : g_match
    logic unused_bits;
    assign match[gi] = (entry_i[gi].state != SB_FREE) &&
                       (entry_i[gi].addr[31:2] == ld_addr_i[31:2]);
`ifdef STORE_BUFFER_FWD_EN
    assign unused_bits = ^entry_i[gi].addr[1:0];
`else
    assign unused_bits = ^{entry_i[gi].addr[1:0], entry_i[gi].size, entry_i[gi].data};
`endif
  end

`ifdef STORE_BUFFER_FWD_EN
  store_buffer_idx_t scan_idx;
  logic              found;
  sb_size_t          young_size;
  logic [31:0]       young_data;

  // Walk oldest to youngest starting at head so the last hit is the youngest.
  always_comb begin
    found      = 1'b0;
    young_size = SB_WORD;
    young_data = '0;
    scan_idx   = head_i;
    for (int k = 0; k < STORE_BUFFER_SIZE; k++) begin
      scan_idx = head_i + store_buffer_idx_t'(k);
      if (match[scan_idx]) begin
        found      = 1'b1;
        young_size = entry_i[scan_idx].size;
        young_data = entry_i[scan_idx].data;
      end
    end
  end

  assign fwd_hit_o  = found && (young_size == SB_WORD);
  assign fwd_data_o = fwd_hit_o ? young_data : 32'h0;
  assign stall_o    = found && (young_size != SB_WORD);
`else
  logic unused_head;

  assign unused_head = ^head_i;
  assign fwd_hit_o   = 1'b0;
  assign fwd_data_o  = 32'h0;
  assign stall_o     = |match;
`endif

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: allocate at tail, commit in order at cmt, drain from head.
// Load forwarding is selected by STORE_BUFFER_FWD_EN inside store_buffer_fwd.
module store_buffer
  import tartaruga_pkg::*;
(
  input logic           clk_i,
  input logic           rst_i,
  store_buffer_if.slave sb
);

  sb_entry_t                    entry_reg  [STORE_BUFFER_SIZE];
  sb_entry_t                    entry_next [STORE_BUFFER_SIZE];
  store_buffer_idx_t            head_reg, head_next;
  store_buffer_idx_t            cmt_reg, cmt_next;
  store_buffer_idx_t            tail_reg, tail_next;
  logic [STORE_BUFFER_SIZE-1:0] busy;
  logic                         full;
  logic                         discard_any;
  logic                         alloc_fire;
  logic                         commit_fire;
  logic                         drain_fire;
  sb_entry_t                    head_entry;

  for (genvar gi = 0; gi < STORE_BUFFER_SIZE; gi++) begin : g_busy
    assign busy[gi] = (entry_reg[gi].state != SB_FREE);
  end

  // Occupancy comes from registered state only, so a drain never frees a slot
  // for an alloc in the same cycle.
  assign full        = &busy;
  assign head_entry  = entry_reg[head_reg];
  assign discard_any = |sb.discard_i;
  assign alloc_fire  = sb.alloc_valid_i && !full && !discard_any;
  assign commit_fire = sb.commit_valid_i && (sb.commit_idx_i == cmt_reg) &&
                       (entry_reg[cmt_reg].state == SB_PENDING);
  assign drain_fire  = (head_entry.state == SB_COMMITTED) && sb.mem_req_ready_i;

  always_comb begin
    entry_next = entry_reg;
    head_next  = head_reg;
    cmt_next   = cmt_reg;
    tail_next  = tail_reg;

    // Commit is applied before discard so the retiring store survives a squash.
    if (commit_fire) begin
      entry_next[cmt_reg].state = SB_COMMITTED;
      cmt_next                  = cmt_reg + store_buffer_idx_t'(1);
    end

    if (discard_any) begin
      for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
        if (sb.discard_i[i] && (entry_next[i].state == SB_PENDING)) begin
          entry_next[i].state = SB_FREE;
        end
      end
      tail_next = cmt_next;
    end

    if (alloc_fire) begin
      entry_next[tail_reg] = '{state: SB_PENDING,
                               size:  sb_size_t'(sb.alloc_size_i),
                               addr:  sb.alloc_addr_i,
                               data:  sb.alloc_data_i};
      tail_next            = tail_reg + store_buffer_idx_t'(1);
    end

    if (drain_fire) begin
      entry_next[head_reg].state = SB_FREE;
      head_next                  = head_reg + store_buffer_idx_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
        entry_reg[i] <= '0;
      end
      head_reg <= '0;
      cmt_reg  <= '0;
      tail_reg <= '0;
    end else begin
      entry_reg <= entry_next;
      head_reg  <= head_next;
      cmt_reg   <= cmt_next;
      tail_reg  <= tail_next;
    end
  end

  // Memory-side outputs are decoded from the head entry, which cannot change
  // while it waits for ready, so they hold stable through backpressure.
  assign sb.mem_req_valid_o = (head_entry.state == SB_COMMITTED);
  assign sb.mem_addr_o      = {head_entry.addr[31:2], 2'b00};
  assign sb.mem_data_o      = sb_lane_data(head_entry.size, head_entry.data);
  assign sb.mem_be_o        = sb_byte_en(head_entry.size, head_entry.addr[1:0]);

  assign sb.alloc_ready_o = !full;
  assign sb.alloc_idx_o   = tail_reg;
  assign sb.full_o        = full;
  assign sb.empty_o       = ~|busy;

  store_buffer_fwd u_fwd (
    .entry_i    (entry_reg),
    .head_i     (head_reg),
    .ld_addr_i  (sb.ld_addr_i),
    .fwd_hit_o  (sb.ld_fwd_hit_o),
    .fwd_data_o (sb.ld_fwd_data_o),
    .stall_o    (sb.ld_stall_o)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (STORE_BUFFER_SIZE=4); forwarding expectations
// follow STORE_BUFFER_FWD_EN.
module tb_store_buffer;
  import tartaruga_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  store_buffer_if sb_if ();

  store_buffer dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sb    (sb_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sb_alloc(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic [31:0] exp_idx);
    sb_if.alloc_valid_i = 1'b1;
    sb_if.alloc_addr_i  = addr;
    sb_if.alloc_data_i  = data;
    sb_if.alloc_size_i  = size;
    #1;
    check_eq("alloc_idx", 32'(sb_if.alloc_idx_o), exp_idx);
    $display("alloc addr=0x%08h data=0x%08h size=%0d idx=%0d ready=%0b",
             addr, data, size, sb_if.alloc_idx_o, sb_if.alloc_ready_o);
    cyc();
    sb_if.alloc_valid_i = 1'b0;
  endtask

  task automatic sb_commit(input logic [1:0] idx);
    sb_if.commit_valid_i = 1'b1;
    sb_if.commit_idx_i   = idx;
    $display("commit idx=%0d", idx);
    cyc();
    sb_if.commit_valid_i = 1'b0;
  endtask

  task automatic sb_discard(input logic [3:0] mask);
    sb_if.discard_i = mask;
    $display("discard mask=%b", mask);
    cyc();
    sb_if.discard_i = '0;
  endtask

  task automatic check_ld(input logic [31:0] addr, input logic exp_hit,
                          input logic [31:0] exp_data, input logic exp_stall);
    sb_if.ld_addr_i = addr;
    #1;
    $display("load lookup addr=0x%08h hit=%0b data=0x%08h stall=%0b",
             addr, sb_if.ld_fwd_hit_o, sb_if.ld_fwd_data_o, sb_if.ld_stall_o);
    check_eq("ld_fwd_hit", 32'(sb_if.ld_fwd_hit_o), 32'(exp_hit));
    check_eq("ld_fwd_data", sb_if.ld_fwd_data_o, exp_data);
    check_eq("ld_stall", 32'(sb_if.ld_stall_o), 32'(exp_stall));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_if.alloc_valid_i   = 1'b0;
    sb_if.alloc_addr_i    = '0;
    sb_if.alloc_data_i    = '0;
    sb_if.alloc_size_i    = '0;
    sb_if.commit_valid_i  = 1'b0;
    sb_if.commit_idx_i    = '0;
    sb_if.discard_i       = '0;
    sb_if.mem_req_ready_i = 1'b0;
    sb_if.ld_addr_i       = '0;

    repeat (3) cyc();
    rst_i = 1'b0;
    #1;
    $display("reset released");
    check_eq("rst_mem_valid", 32'(sb_if.mem_req_valid_o), 32'd0);
    check_eq("rst_fwd_hit", 32'(sb_if.ld_fwd_hit_o), 32'd0);
    check_eq("rst_stall", 32'(sb_if.ld_stall_o), 32'd0);
    check_eq("rst_ready", 32'(sb_if.alloc_ready_o), 32'd1);
    check_eq("rst_empty", 32'(sb_if.empty_o), 32'd1);
    check_eq("rst_full", 32'(sb_if.full_o), 32'd0);
    check_eq("rst_tail", 32'(sb_if.alloc_idx_o), 32'd0);

    // Fill, overflow attempt, full squash.
    for (int i = 0; i < 4; i++) begin
      sb_alloc(32'h1000 + 32'(i * 4), 32'h10 + 32'(i), 2'd2, 32'(i));
    end
    check_eq("fill_full", 32'(sb_if.full_o), 32'd1);
    check_eq("fill_ready", 32'(sb_if.alloc_ready_o), 32'd0);
    sb_alloc(32'h2000, 32'h55, 2'd2, 32'd0);
    check_eq("drop_full", 32'(sb_if.full_o), 32'd1);
    check_eq("drop_tail", 32'(sb_if.alloc_idx_o), 32'd0);
    sb_discard(4'b1111);
    check_eq("squash_empty", 32'(sb_if.empty_o), 32'd1);
    check_eq("squash_tail", 32'(sb_if.alloc_idx_o), 32'd0);

    // Single word store, commit, immediate drain.
    sb_if.mem_req_ready_i = 1'b1;
    sb_alloc(32'h100, 32'hDEADBEEF, 2'd2, 32'd0);
    check_eq("word_not_empty", 32'(sb_if.empty_o), 32'd0);
    sb_commit(2'd0);
    check_eq("word_valid", 32'(sb_if.mem_req_valid_o), 32'd1);
    check_eq("word_addr", sb_if.mem_addr_o, 32'h100);
    check_eq("word_be", 32'(sb_if.mem_be_o), 32'hF);
    check_eq("word_data", sb_if.mem_data_o, 32'hDEADBEEF);
    cyc();
    check_eq("word_drained_empty", 32'(sb_if.empty_o), 32'd1);
    check_eq("word_drained_valid", 32'(sb_if.mem_req_valid_o), 32'd0);

    // Byte store under backpressure.
    sb_if.mem_req_ready_i = 1'b0;
    sb_alloc(32'h203, 32'hAB, 2'd0, 32'd1);
    sb_commit(2'd1);
    for (int c = 0; c < 3; c++) begin
      check_eq("bp_valid", 32'(sb_if.mem_req_valid_o), 32'd1);
      check_eq("bp_be", 32'(sb_if.mem_be_o), 32'h8);
      check_eq("bp_data", sb_if.mem_data_o, 32'hABABABAB);
      check_eq("bp_addr", sb_if.mem_addr_o, 32'h200);
      cyc();
    end
    sb_if.mem_req_ready_i = 1'b1;
    #1;
    check_eq("bp_release_valid", 32'(sb_if.mem_req_valid_o), 32'd1);
    cyc();
    sb_if.mem_req_ready_i = 1'b0;
    check_eq("bp_drained_empty", 32'(sb_if.empty_o), 32'd1);

    // Alloc and discard in the same cycle: alloc dropped.
    sb_if.alloc_valid_i = 1'b1;
    sb_if.alloc_addr_i  = 32'h300;
    sb_if.alloc_size_i  = 2'd2;
    sb_if.discard_i     = 4'b0001;
    $display("alloc addr=0x00000300 with discard mask=0001");
    cyc();
    sb_if.alloc_valid_i = 1'b0;
    sb_if.discard_i     = '0;
    check_eq("alloc_vs_discard_empty", 32'(sb_if.empty_o), 32'd1);
    check_eq("alloc_vs_discard_tail", 32'(sb_if.alloc_idx_o), 32'd2);

    // Wrap, then commit idx 2 together with a discard of 3 and 0.
    sb_alloc(32'h400, 32'h4, 2'd2, 32'd2);
    sb_alloc(32'h404, 32'h5, 2'd2, 32'd3);
    sb_alloc(32'h408, 32'h6, 2'd2, 32'd0);
    sb_if.commit_valid_i = 1'b1;
    sb_if.commit_idx_i   = 2'd2;
    sb_if.discard_i      = 4'b1001;
    $display("commit idx=2 with discard mask=1001");
    cyc();
    sb_if.commit_valid_i = 1'b0;
    sb_if.discard_i      = '0;
    check_eq("cd_tail", 32'(sb_if.alloc_idx_o), 32'd3);
    check_eq("cd_valid", 32'(sb_if.mem_req_valid_o), 32'd1);
    check_eq("cd_addr", sb_if.mem_addr_o, 32'h400);
    check_eq("cd_not_empty", 32'(sb_if.empty_o), 32'd0);
    sb_if.mem_req_ready_i = 1'b1;
    cyc();
    sb_if.mem_req_ready_i = 1'b0;
    check_eq("cd_empty", 32'(sb_if.empty_o), 32'd1);
    check_eq("cd_drained_valid", 32'(sb_if.mem_req_valid_o), 32'd0);

    // Out-of-order commit index is ignored.
    sb_alloc(32'h500, 32'h7, 2'd2, 32'd3);
    sb_commit(2'd0);
    check_eq("bad_commit_valid", 32'(sb_if.mem_req_valid_o), 32'd0);
    sb_commit(2'd3);
    check_eq("good_commit_valid", 32'(sb_if.mem_req_valid_o), 32'd1);
    check_eq("good_commit_addr", sb_if.mem_addr_o, 32'h500);
    sb_if.mem_req_ready_i = 1'b1;
    cyc();
    sb_if.mem_req_ready_i = 1'b0;
    check_eq("good_commit_empty", 32'(sb_if.empty_o), 32'd1);

    // Load lookup against pending stores.
    sb_alloc(32'h40, 32'h1, 2'd2, 32'd0);
    sb_alloc(32'h40, 32'h2, 2'd2, 32'd1);
`ifdef STORE_BUFFER_FWD_EN
    check_ld(32'h40, 1'b1, 32'h2, 1'b0);
`else
    check_ld(32'h40, 1'b0, 32'h0, 1'b1);
`endif
    sb_alloc(32'h42, 32'h3, 2'd1, 32'd2);
    check_ld(32'h40, 1'b0, 32'h0, 1'b1);
    check_ld(32'h44, 1'b0, 32'h0, 1'b0);
    sb_if.ld_addr_i = '0;
    sb_discard(4'b0111);
    check_eq("fwd_cleanup_empty", 32'(sb_if.empty_o), 32'd1);
    check_eq("fwd_cleanup_tail", 32'(sb_if.alloc_idx_o), 32'd0);

    // Reset while a request is stalled.
    sb_alloc(32'h700, 32'h77, 2'd2, 32'd0);
    sb_commit(2'd0);
    check_eq("pre_rst_valid", 32'(sb_if.mem_req_valid_o), 32'd1);
    rst_i = 1'b1;
    $display("reset during stalled request");
    cyc();
    rst_i = 1'b0;
    check_eq("mid_rst_valid", 32'(sb_if.mem_req_valid_o), 32'd0);
    check_eq("mid_rst_empty", 32'(sb_if.empty_o), 32'd1);
    check_eq("mid_rst_tail", 32'(sb_if.alloc_idx_o), 32'd0);
    check_eq("mid_rst_ready", 32'(sb_if.alloc_ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
